ysyx_201979054_burst_line_buffer: RTL and testbench

//  Parametrised cache-line staging buffer between the cache and the AXI master.

---
 rtl/ysyx_201979054_lb_pkg.sv | 16 +
 rtl/ysyx_201979054_burst_line_buffer.sv | 167 ++++++++++++++++
 tb/tb_ysyx_201979054_burst_line_buffer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_201979054_lb_pkg.sv
// Shared state type and sizing helper for the burst line buffer.
package ysyx_201979054_lb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_lb_state;

    // Beat index width; a single-beat line still gets a one-bit index.
    function automatic int lb_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ysyx_201979054_burst_line_buffer.sv
// Cache-line staging buffer: FILL assembles an AXI read burst into a line, DRAIN
// serialises a loaded line into a write burst. Macro WRAP_EN adds i_start_beat.
module ysyx_201979054_burst_line_buffer
    import ysyx_201979054_lb_pkg::*;
#(
    parameter int  AXI_DATA_WIDTH = 32,
    parameter int  LINE_WIDTH     = 512,
    localparam int BEATS          = LINE_WIDTH / AXI_DATA_WIDTH,
    localparam int IDX_W          = lb_idx_w(BEATS)
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      i_fill_start,
    input  logic                      i_load,
    input  logic [LINE_WIDTH-1:0]     i_line,
`ifdef WRAP_EN
    input  logic [IDX_W-1:0]          i_start_beat,
`endif
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [AXI_DATA_WIDTH-1:0] s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [AXI_DATA_WIDTH-1:0] m_data,
    output logic                      m_last,
    output logic [LINE_WIDTH-1:0]     o_line,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(BEATS - 1);

    t_lb_state                 state_r;
    logic [IDX_W-1:0]          idx_r;
    logic [IDX_W-1:0]          cnt_r;
    logic                      s_ready_r;
    logic                      m_valid_r;
    logic                      m_last_r;
    logic                      done_r;
    logic                      err_r;
    logic [AXI_DATA_WIDTH-1:0] beat_r [BEATS];

    logic [IDX_W-1:0]          start_idx_s;
    logic [IDX_W-1:0]          idx_inc_s;
    logic [IDX_W-1:0]          cnt_inc_s;
    logic                      fill_go_s;
    logic                      load_go_s;
    logic                      s_fire_s;
    logic                      m_fire_s;
    logic                      cnt_last_s;

`ifdef WRAP_EN
    // An out-of-range start beat (non power-of-two line) falls back to beat 0.
    assign start_idx_s = (i_start_beat <= LAST) ? i_start_beat : '0;
`else
    assign start_idx_s = '0;
`endif

    assign fill_go_s  = (state_r == IDLE) & i_fill_start;
    assign load_go_s  = (state_r == IDLE) & ~i_fill_start & i_load;
    assign s_fire_s   = s_ready_r & s_valid;
    assign m_fire_s   = m_valid_r & m_ready;
    assign cnt_last_s = (cnt_r == LAST);
    assign idx_inc_s  = (idx_r == LAST) ? '0 : idx_r + IDX_W'(1);
    assign cnt_inc_s  = cnt_r + IDX_W'(1);

    // Sequencer: state, beat index/count, handshake flags, done pulse, sticky error.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            cnt_r     <= '0;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (fill_go_s) begin
                        state_r   <= FILL;
                        idx_r     <= start_idx_s;
                        cnt_r     <= '0;
                        err_r     <= 1'b0;
                        s_ready_r <= 1'b1;
                    end else if (load_go_s) begin
                        state_r   <= DRAIN;
                        idx_r     <= start_idx_s;
                        cnt_r     <= '0;
                        m_valid_r <= 1'b1;
                        m_last_r  <= (LAST == '0);
                    end
                end
                FILL: begin
                    if (s_fire_s) begin
                        idx_r <= idx_inc_s;
                        cnt_r <= cnt_inc_s;
                        if (s_last != cnt_last_s) begin
                            err_r <= 1'b1;
                        end
                        if (cnt_last_s) begin
                            state_r   <= DONE;
                            s_ready_r <= 1'b0;
                            done_r    <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (m_fire_s) begin
                        idx_r    <= idx_inc_s;
                        cnt_r    <= cnt_inc_s;
                        m_last_r <= (cnt_inc_s == LAST);
                        if (cnt_last_s) begin
                            state_r   <= DONE;
                            m_valid_r <= 1'b0;
                            m_last_r  <= 1'b0;
                            done_r    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    s_ready_r <= 1'b0;
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    // Line storage: bulk load for DRAIN, one beat per accepted read beat in FILL.
    always_ff @(posedge clk) begin
        if (arst) begin
            for (int k = 0; k < BEATS; k++) begin
                beat_r[k] <= '0;
            end
        end else if (load_go_s) begin
            for (int k = 0; k < BEATS; k++) begin
                beat_r[k] <= i_line[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end else if (s_fire_s) begin
            beat_r[idx_r] <= s_data;
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign o_line[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = beat_r[g];
    end

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign m_last  = m_last_r;
    assign m_data  = beat_r[idx_r];
    assign o_busy  = (state_r != IDLE);
    assign o_done  = done_r;
    assign o_err   = err_r;

endmodule

// File: tb/tb_ysyx_201979054_burst_line_buffer.sv
// Self-checking bench for the burst line buffer (default 32-bit beats, 16-beat line).
module tb_ysyx_201979054_burst_line_buffer;

    localparam int W  = 32;
    localparam int LW = 512;
    localparam int NB = LW / W;

    logic          clk = 1'b0;
    logic          arst;
    logic          i_fill_start;
    logic          i_load;
    logic [LW-1:0] i_line;
`ifdef WRAP_EN
    logic [3:0]    i_start_beat;
`endif
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic [LW-1:0] o_line;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    always #5 clk = ~clk;

    ysyx_201979054_burst_line_buffer #(.AXI_DATA_WIDTH(W), .LINE_WIDTH(LW)) dut (
        .clk(clk), .arst(arst), .i_fill_start(i_fill_start), .i_load(i_load),
        .i_line(i_line),
`ifdef WRAP_EN
        .i_start_beat(i_start_beat),
`endif
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .o_line(o_line), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the line as an array of beats plus the sticky error bit.
    logic [W-1:0] m_line [NB];
    logic         m_err;
    logic [W-1:0] beat_data [NB];

    typedef struct {
        bit         is_fill;
        logic [3:0] start;
        int         last_pos;
        logic [31:0] base;
        int         gap;
        bit         exp_err;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [LW-1:0] model_flat();
        logic [LW-1:0] v;
        for (int k = 0; k < NB; k++) v[k*W +: W] = m_line[k];
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input logic [3:0] start, input int last_pos, input int gap);
        int k, cyc, sidx;
        bit hs;
`ifdef WRAP_EN
        sidx = int'(start);
        i_start_beat = start;
`else
        sidx = 0;
        if (start != 4'd0) sidx = 0;
`endif
        i_fill_start = 1'b1;
        i_load       = 1'($urandom_range(1));
        i_line       = {16{$urandom}};
        tick();
        i_fill_start = 1'b0;
        i_load       = 1'b0;
        m_err        = 1'b0;
        check_bit("fill_ready_first", s_ready, 1'b1);
        check_bit("fill_busy", o_busy, 1'b1);
        check_bit("fill_no_mvalid", m_valid, 1'b0);
        k = 0;
        cyc = 0;
        while (k < NB && cyc < 2000) begin
            s_valid = (gap == 0) || (int'($urandom_range(99)) >= gap);
            s_data  = beat_data[k];
            s_last  = (k == last_pos);
            i_load  = ($urandom_range(3) == 0);
            hs      = s_valid;
            check_bit("fill_ready", s_ready, 1'b1);
            tick();
            cyc++;
            if (hs) begin
                m_line[(sidx + k) % NB] = beat_data[k];
                if ((k == last_pos) != (k == NB - 1)) m_err = 1'b1;
                k++;
            end
            if (k < NB) check_bit("fill_no_early_done", o_done, 1'b0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        i_load  = 1'b0;
        check_int("fill_beats", k, NB);
        if (gap == 0) check_int("fill_latency", cyc, NB);
        check_bit("fill_done", o_done, 1'b1);
        check_bit("fill_ready_off", s_ready, 1'b0);
        check_bit("fill_err", o_err, m_err);
        check_vec("fill_line", o_line, model_flat());
        tick();
        check_bit("fill_done_pulse", o_done, 1'b0);
        check_bit("fill_idle", o_busy, 1'b0);
        check_vec("fill_line_hold", o_line, model_flat());
    endtask

    task automatic run_drain(input logic [3:0] start, input int gap);
        int k, cyc, sidx;
        bit rdy;
        logic [LW-1:0] line;
`ifdef WRAP_EN
        sidx = int'(start);
        i_start_beat = start;
`else
        sidx = 0;
        if (start != 4'd0) sidx = 0;
`endif
        for (int j = 0; j < NB; j++) begin
            line[j*W +: W] = beat_data[j];
            m_line[j] = beat_data[j];
        end
        i_load = 1'b1;
        i_line = line;
        tick();
        i_load = 1'b0;
        i_line = {16{$urandom}};
        check_bit("drain_sready_off", s_ready, 1'b0);
        k = 0;
        cyc = 0;
        while (k < NB && cyc < 2000) begin
            rdy = (gap < 0) ? (cyc % 2 == 0) : ((gap == 0) || (int'($urandom_range(99)) >= gap));
            m_ready      = rdy;
            i_fill_start = ($urandom_range(3) == 0);
            check_bit("drain_valid", m_valid, 1'b1);
            check_vec("drain_data", LW'(m_data), LW'(m_line[(sidx + k) % NB]));
            check_bit("drain_last", m_last, (k == NB - 1));
            tick();
            cyc++;
            if (rdy) k++;
        end
        m_ready      = 1'b0;
        i_fill_start = 1'b0;
        check_int("drain_beats", k, NB);
        check_bit("drain_done", o_done, 1'b1);
        check_bit("drain_valid_off", m_valid, 1'b0);
        check_bit("drain_err_hold", o_err, m_err);
        check_vec("drain_line", o_line, model_flat());
        tick();
        check_bit("drain_done_pulse", o_done, 1'b0);
        check_bit("drain_idle", o_busy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check_bit({tag, "_busy"}, o_busy, 1'b0);
        check_bit({tag, "_sready"}, s_ready, 1'b0);
        check_bit({tag, "_mvalid"}, m_valid, 1'b0);
        check_bit({tag, "_mlast"}, m_last, 1'b0);
        check_bit({tag, "_done"}, o_done, 1'b0);
        check_bit({tag, "_err"}, o_err, 1'b0);
        check_vec({tag, "_line"}, o_line, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst = 1'b1; i_fill_start = 1'b0; i_load = 1'b0; i_line = '0;
`ifdef WRAP_EN
        i_start_beat = 4'd0;
`endif
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        for (int k = 0; k < NB; k++) m_line[k] = '0;
        m_err = 1'b0;

        tbl[0] = '{1'b1, 4'd0, 15, 32'h0000_1000, 0,  1'b0};
        tbl[1] = '{1'b0, 4'd0, 15, 32'h0000_00A0, -1, 1'b0};
        tbl[2] = '{1'b1, 4'd0, 7,  32'h0000_2000, 0,  1'b1};
        tbl[3] = '{1'b1, 4'd0, 15, 32'h0000_3000, 30, 1'b0};
        tbl[4] = '{1'b0, 4'd3, 15, 32'h5555_0000, 0,  1'b0};
        tbl[5] = '{1'b1, 4'd9, 15, 32'h0000_0040, 20, 1'b0};

        repeat (3) tick();
        arst = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NB; k++) beat_data[k] = tbl[i].base + 32'(k);
            if (tbl[i].is_fill) run_fill(tbl[i].start, tbl[i].last_pos, tbl[i].gap);
            else                run_drain(tbl[i].start, tbl[i].gap);
            check_bit("tbl_err", o_err, tbl[i].exp_err);
        end

`ifdef WRAP_EN
        for (int k = 0; k < NB; k++) beat_data[k] = 32'(k);
        run_fill(4'd5, 15, 0);
        check_vec("wrap_beat0", LW'(o_line[31:0]), LW'(32'd11));
`endif

        // Simultaneous fill start and load: FILL wins, i_line is not latched.
        i_fill_start = 1'b1;
        i_load       = 1'b1;
        i_line       = {16{32'hDEAD_BEEF}};
        tick();
        i_fill_start = 1'b0;
        i_load       = 1'b0;
        check_bit("both_sready", s_ready, 1'b1);
        check_bit("both_mvalid", m_valid, 1'b0);
        check_vec("both_line", o_line, model_flat());
        arst = 1'b1;
        tick();
        arst = 1'b0;
        for (int k = 0; k < NB; k++) m_line[k] = '0;
        m_err = 1'b0;
        check_reset_state("both_reset");

        // Reset six beats into a fill: burst aborts, no done pulse.
        for (int k = 0; k < NB; k++) beat_data[k] = 32'h0000_1000 + 32'(k);
        run_fill(4'd0, 15, 0);
        i_fill_start = 1'b1;
        tick();
        i_fill_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            s_last  = 1'b0;
            tick();
        end
        s_valid = 1'b0;
        arst    = 1'b1;
        tick();
        arst    = 1'b0;
        for (int k = 0; k < NB; k++) m_line[k] = '0;
        m_err = 1'b0;
        check_reset_state("abort");
        for (int k = 0; k < 4; k++) begin
            tick();
            check_bit("abort_no_done", o_done, 1'b0);
        end

        // Randomised bursts against the model.
        for (int i = 0; i < 24; i++) begin
            int last_pos;
            for (int k = 0; k < NB; k++) beat_data[k] = $urandom;
            last_pos = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : 15;
            if ($urandom_range(1) == 1)
                run_fill(4'($urandom_range(15)), last_pos, int'($urandom_range(60)));
            else
                run_drain(4'($urandom_range(15)), int'($urandom_range(60)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
